// File: rtl/op_alu_pkg.sv
// op_alu_pkg: sel encodings shared with the operation selector, and the ALU FSM states
package op_alu_pkg;
  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_SUB     = 3'd2;
  localparam logic [2:0] OP_LEFT    = 3'd3;
  localparam logic [2:0] OP_RIGHT   = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_DIV     = 3'd6;
  localparam logic [2:0] OP_NONE_HI = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;
endpackage

// File: rtl/op_alu_iter.sv
// op_alu_iter: one-bit-per-cycle shift-add multiplier and restoring divider
// The divide path exists only when OP_ALU_DIV_EN is defined.
module op_alu_iter
  import op_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               en_i,
`ifdef OP_ALU_DIV_EN
  input  logic               is_div_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q, p_d, mul_nx;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH:0]     sum;
  logic               swap;
  // p_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_nx = {sum, p_q[WIDTH-1:1]};
`ifdef OP_ALU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     shl, dif;
  logic [2*WIDTH-1:0] div_nx;
  assign swap   = is_div_i;
  assign shl    = p_q[2*WIDTH-1:WIDTH-1];
  assign dif    = shl - {1'b0, m_q};
  assign div_nx = dif[WIDTH] ? {shl[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                             : {dif[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  assign p_d    = div_q ? div_nx : mul_nx;
  always_ff @(posedge clk) begin
    if (reset) div_q <= 1'b0;
    else if (load_i) div_q <= is_div_i;
  end
`else
  assign swap = 1'b0;
  assign p_d  = mul_nx;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      p_q   <= '0;
      m_q   <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      p_q   <= {{WIDTH{1'b0}}, swap ? a_i : b_i};
      m_q   <= swap ? b_i : a_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
      p_q   <= p_d;
    end
  end
  assign last_o   = cnt_q == CW'(WIDTH - 1);
  assign result_o = p_d;
endmodule

// File: rtl/op_alu_seq.sv
// op_alu_seq: multi-cycle ALU with start/busy/done handshake driven by the op selector
// DIV support is built only when OP_ALU_DIV_EN is defined; otherwise sel=6 acts as NONE.
module op_alu_seq
  import op_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q;
  logic [2*WIDTH-1:0] result_q, simple_d, iter_res, ax, bx;
  logic [WIDTH-1:0]   diff;
  logic [CW-1:0]      shamt;
  logic               busy_q, done_q, dbz_q;
  logic               accept, iter_op, is_div, dz_d, last;
`ifdef OP_ALU_DIV_EN
  assign is_div = sel == OP_DIV;
`else
  assign is_div = 1'b0;
`endif
  assign accept  = start && state_q != ST_ITER;
  assign dz_d    = is_div && b == '0;
  assign iter_op = sel == OP_MUL || (is_div && b != '0);
  always_comb begin
    diff     = a - b;
    ax       = {{WIDTH{1'b0}}, a};
    bx       = {{WIDTH{1'b0}}, b};
    shamt    = CW'(32'(b) % WIDTH);
    simple_d = sel == OP_ADD   ? ax + bx :
               sel == OP_SUB   ? {{(WIDTH-1){1'b0}}, a < b, diff} :
               sel == OP_LEFT  ? ax << shamt :
               sel == OP_RIGHT ? ax >> shamt :
               dz_d            ? {a, {WIDTH{1'b1}}} : '0;
  end
  op_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept && iter_op),
    .en_i     (state_q == ST_ITER),
`ifdef OP_ALU_DIV_EN
    .is_div_i (is_div),
`endif
    .a_i      (a),
    .b_i      (b),
    .last_o   (last),
    .result_o (iter_res)
  );
  // A start in the DONE cycle is accepted directly, so simple ops can complete every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && iter_op) begin
        state_q <= ST_ITER;
        busy_q  <= 1'b1;
      end else if (accept) begin
        state_q  <= ST_DONE;
        done_q   <= 1'b1;
        result_q <= simple_d;
        dbz_q    <= dz_d;
      end else if (state_q == ST_ITER && last) begin
        state_q  <= ST_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= iter_res;
        dbz_q    <= 1'b0;
      end else if (state_q == ST_DONE) begin
        state_q <= ST_IDLE;
      end
    end
  end
  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_op_alu_seq.sv
// tb_op_alu_seq: directed vectors with a scoreboard queue checked on every done pulse
module tb_op_alu_seq;
  import op_alu_pkg::*;
  localparam int W = 8;
`ifdef OP_ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int             due;
  } exp_t;
  logic           clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]     sel = 3'd0;
  logic [W-1:0]   a = '0, b = '0;
  logic [2*W-1:0] result;
  logic           busy, done, div_by_zero;
  exp_t q[$];
  int cyc = 0, compared = 0, mismatched = 0, busy_cnt = 0;
  op_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .a           (a),
    .b           (b),
    .start       (start),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end
  task automatic go(input logic [2:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic [2*W-1:0] r, input logic ez, input int lat);
    @(negedge clk);
    sel = s; a = aa; b = bb; start = 1'b1;
    q.push_back('{res: r, dz: ez, due: cyc + lat});
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_q();
    idle();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    go(OP_ADD,   8'd200, 8'd100, 16'h012C, 1'b0, 1);
    go(OP_SUB,   8'd5,   8'd7,   16'h01FE, 1'b0, 1);
    go(OP_LEFT,  8'h81,  8'd3,   16'h0408, 1'b0, 1);
    go(OP_RIGHT, 8'h81,  8'd3,   16'h0010, 1'b0, 1);
    go(OP_LEFT,  8'h01,  8'd9,   16'h0002, 1'b0, 1);
    go(OP_NONE_HI, 8'h55, 8'h33, 16'h0000, 1'b0, 1);
    go(OP_NONE,  8'h55,  8'h33,  16'h0000, 1'b0, 1);
    wait_q();
    chk("busy_simple", busy_cnt, 32'd0);
    busy_cnt = 0;
    go(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, W + 1);
    idle();
    @(negedge clk);
    @(negedge clk);
    sel = OP_ADD; a = 8'd1; b = 8'd1; start = 1'b1;
    wait_q();
    chk("mul_busy_cycles", busy_cnt, 32'd8);
    go(OP_MUL, 8'd16, 8'd3, 16'h0030, 1'b0, W + 1);
    idle();
    repeat (7) @(negedge clk);
    go(OP_ADD, 8'd3, 8'd4, 16'h0007, 1'b0, 1);
    wait_q();
    go(OP_DIV, 8'd100, 8'd7, DIV_ON ? 16'h020E : 16'h0000, 1'b0, DIV_ON ? W + 1 : 1);
    wait_q();
    go(OP_DIV, 8'd9, 8'd0, DIV_ON ? 16'h09FF : 16'h0000, DIV_ON, 1);
    go(OP_ADD, 8'd2, 8'd3, 16'h0005, 1'b0, 1);
    wait_q();
    go(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, W + 1);
    idle();
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk_zero("midop_reset");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    go(OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0, 1);
    wait_q();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/op_alu_seq.md
# op_alu_seq

Multi-cycle arithmetic unit that consumes the 3-bit operation select produced by the button-driven operation selector and executes the chosen operation on two unsigned operands. Simple ops (add, subtract, shifts) complete in one cycle. Multiply and divide run iteratively, one bit per cycle. A start/busy/done handshake lets the display and result logic downstream capture each result exactly once.

## Interface
- `WIDTH`, default 8: operand width in bits; result is 2*WIDTH bits wide.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `sel`  in  3: operation select, sampled only when a start is accepted.
- `a`  in  WIDTH: operand A, sampled only when a start is accepted.
- `b`  in  WIDTH: operand B, sampled only when a start is accepted.
- `start`  in  1: request to execute; accepted when `busy`=0.
- `result`  out  2*WIDTH: registered result, held until the next `done`.
- `busy`  out  1: iterative operation in progress.
- `done`  out  1: one-cycle pulse; `result` and `div_by_zero` are valid from this cycle onward.
- `div_by_zero`  out  1: DIV was issued with b=0; updated together with `done`.

## Operation
- Encoding (shared with selector): 0 NONE, 1 ADD, 2 SUB, 3 LEFT, 4 RIGHT, 5 MUL, 6 DIV, 7 NONE.
- FSM states:
  - IDLE: start accepted goes to DONE for simple ops, ITER for MUL/DIV with b≠0.
  - ITER: WIDTH cycles, then DONE.
  - DONE: one cycle, asserts `done`; next state is IDLE, or a new accept occurs directly.
- On accept, `sel`, `a` and `b` are latched. Inputs are ignored at all other times.
- `start` is ignored while `busy`=1 and is never queued.
- ADD: result = zero-extended a+b; carry lands in bit WIDTH; upper bits are 0.
- SUB: result[WIDTH-1:0] = a-b mod 2^WIDTH; bit WIDTH = borrow (a<b); upper bits are 0.
- LEFT: result = a << (b mod WIDTH), computed in 2*WIDTH bits with no bits lost.
- RIGHT: result = a >> (b mod WIDTH), logical shift, zero-extended.
- MUL: unsigned shift-add; result = a*b, full 2*WIDTH bits.
- DIV: unsigned restoring division; result = {remainder, quotient}.
- DIV with b=0: no iteration; result = {a, all ones}; `div_by_zero`=1.
- NONE (0 or 7): result = 0.
- `div_by_zero` is 0 for every completion other than DIV with b=0.
- Reset at any time: FSM to IDLE, `result`=0, `busy`=0, `done`=0, `div_by_zero`=0. An operation in flight is abandoned and produces no `done`.

## Timing
- Start sampled at the rising edge that ends cycle k.
- Simple ops, NONE and DIV with b=0: `done`=1 in cycle k+1; `busy` stays 0.
- MUL and DIV with b≠0: `busy`=1 in cycles k+1 through k+WIDTH; `done`=1 in cycle k+WIDTH+1, with `busy`=0.
- Back-to-back: a start in the `done` cycle is accepted, so a simple op can complete every cycle.
- `result` changes only at the edge that raises `done`, and on reset.
- Reset values of all outputs are 0.

## Configuration
- `OP_ALU_DIV_EN` defined: DIV is implemented as specified above.
- `OP_ALU_DIV_EN` undefined: the divider is removed.
  - sel=6 behaves as NONE: result 0, `done` at k+1, `div_by_zero` stays 0.
  - MUL is unaffected.

## Structure
- Package `op_alu_pkg` holds:
  - the 3-bit sel encoding constants, the same values the selector module uses;
  - the FSM state enum (IDLE, ITER, DONE).
- Sub-module `op_alu_iter` holds the iterative datapath:
  - WIDTH-cycle counter, partial-product/remainder register, operand shift register;
  - performs shift-add for MUL and restoring divide for DIV;
  - the divide path is guarded by `OP_ALU_DIV_EN`.
- Top level holds the FSM, operand latches, the simple-op datapath and output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD a=200 b=100 → result 0x012C, `done` at k+1, `busy` never high. SUB a=5 b=7 → result 0x01FE.
- LEFT a=0x81 b=3 → 0x0408. RIGHT a=0x81 b=3 → 0x0010. LEFT a=0x01 b=9 → 0x0002 (shift amount mod 8).
- MUL a=255 b=255 → 0xFE01; `busy` high for exactly 8 cycles; `done` at k+9. A start with sel=1 pulsed in busy cycle 3 is ignored.
- DIV a=100 b=7 → 0x020E (quotient 14, remainder 2), `done` at k+9. DIV a=9 b=0 → 0x09FF, `div_by_zero`=1, `done` at k+1. A following ADD clears `div_by_zero`.
- Reset asserted in MUL busy cycle 4 → all outputs 0 the next cycle, no `done`. A subsequent ADD a=1 b=1 → 0x0002 at k+1.
- sel=7 and sel=0 → result 0, `done` at k+1. With `OP_ALU_DIV_EN` undefined, sel=6 a=100 b=7 → result 0, `done` at k+1.
